// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Time-set controller for the basic clock counter chain. The set button walks
// the user through RUN -> SET_H -> SET_M -> COMMIT -> RUN. While the user is
// editing, the counter chain is frozen. On commit, one load pulse carries the
// edited hours/minutes. Holding the increment button auto-repeats. Editing is
// abandoned without a load after TIMEOUT_CYC idle cycles.
//
// Ports:
//   i_sysclk   - system clock, the block's only clock
//   i_reset_n  - asynchronous active-low reset
//   i_set      - debounced set button level
//   i_inc      - debounced increment button level
//   i_hours    - live hours from the counter chain (captured on entry)
//   i_minutes  - live minutes from the counter chain (captured on entry)
//   o_clk_en   - counter chain enable, high only in RUN
//   o_load     - one-cycle load strobe (consumer also clears seconds)
//   o_hours    - shadow hours being edited / loaded
//   o_minutes  - shadow minutes being edited / loaded
//   o_mode     - 00 RUN, 01 SET_H, 10 SET_M, 11 COMMIT
module clock_set_ctrl #(
    parameter int TIMEOUT_CYC    = 500_000_000,
    parameter int REPEAT_DLY_CYC = 25_000_000,
    parameter int REPEAT_CYC     = 5_000_000
) (
    input  logic       i_sysclk,
    input  logic       i_reset_n,
    input  logic       i_set,
    input  logic       i_inc,
    input  logic [4:0] i_hours,
    input  logic [5:0] i_minutes,
    output logic       o_clk_en,
    output logic       o_load,
    output logic [4:0] o_hours,
    output logic [5:0] o_minutes,
    output logic [1:0] o_mode
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_SET_H  = 2'b01,
        ST_SET_M  = 2'b10,
        ST_COMMIT = 2'b11
    } state_t;

    localparam int IDLE_W   = $clog2(TIMEOUT_CYC) + 1;
    localparam int HOLD_MAX = (REPEAT_DLY_CYC > REPEAT_CYC) ? REPEAT_DLY_CYC : REPEAT_CYC;
    localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

    // The idle count seen at an edge is one less than the cycles since the
    // last event, so the limit is one below the timeout length.
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_DLY   = HOLD_W'(REPEAT_DLY_CYC);
    localparam logic [HOLD_W-1:0] HOLD_RPT   = HOLD_W'(REPEAT_CYC);

    state_t              state;
    state_t              next_state;
    logic                set_prev;
    logic                inc_prev;
    logic                set_press;
    logic                inc_press;
    logic                in_set;
    logic                repeat_tick;
    logic                inc_evt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [IDLE_W-1:0]   next_idle;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   next_hold;
    logic                repeating;
    logic                next_repeating;
    logic [4:0]          next_hours;
    logic [5:0]          next_minutes;

    // Edge detection and the increment event. The hold counter measures the
    // initial delay first, then (once 'repeating' is set) restarts each tick
    // and measures the repeat period instead.
    always_comb begin
        set_press   = i_set & ~set_prev;
        inc_press   = i_inc & ~inc_prev;
        in_set      = (state == ST_SET_H) || (state == ST_SET_M);
        repeat_tick = in_set && i_inc &&
                      (repeating ? (hold_cnt == HOLD_RPT) : (hold_cnt == HOLD_DLY));
        inc_evt     = in_set && (inc_press || repeat_tick);
    end

    // Next-state, shadow and counter logic. A set press always beats an
    // increment in the same cycle. The idle and hold counters saturate.
    always_comb begin
        next_state     = state;
        next_hours     = o_hours;
        next_minutes   = o_minutes;
        next_idle      = '0;
        next_hold      = '0;
        next_repeating = 1'b0;

        case (state)
            ST_RUN: begin
                if (set_press) begin
                    next_state   = ST_SET_H;
                    next_hours   = i_hours;
                    next_minutes = i_minutes;
                end
            end
            ST_SET_H: begin
                if (set_press) begin
                    next_state = ST_SET_M;
                end else if (inc_evt) begin
                    next_hours = (o_hours >= 5'd23) ? 5'd0 : o_hours + 5'd1;
                end else if (idle_cnt >= IDLE_LIMIT) begin
                    next_state = ST_RUN;
                end
            end
            ST_SET_M: begin
                if (set_press) begin
                    next_state = ST_COMMIT;
                end else if (inc_evt) begin
                    next_minutes = (o_minutes >= 6'd59) ? 6'd0 : o_minutes + 6'd1;
                end else if (idle_cnt >= IDLE_LIMIT) begin
                    next_state = ST_RUN;
                end
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase

        if (in_set && !set_press && !inc_evt && (idle_cnt != '1)) begin
            next_idle = idle_cnt + IDLE_W'(1);
        end

        // A set press clears the hold count so a held inc restarts its delay
        // from zero in the new edit field.
        if (in_set && i_inc && !set_press) begin
            if (repeat_tick) begin
                next_hold      = HOLD_W'(1);
                next_repeating = 1'b1;
            end else begin
                next_hold      = (hold_cnt != '1) ? hold_cnt + HOLD_W'(1) : hold_cnt;
                next_repeating = repeating;
            end
        end
    end

    // State register.
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs, edge registers and counters.
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            set_prev  <= 1'b0;
            inc_prev  <= 1'b0;
            idle_cnt  <= '0;
            hold_cnt  <= '0;
            repeating <= 1'b0;
            o_load    <= 1'b0;
            o_hours   <= 5'd0;
            o_minutes <= 6'd0;
            o_mode    <= 2'b00;
        end else begin
            set_prev  <= i_set;
            inc_prev  <= i_inc;
            idle_cnt  <= next_idle;
            hold_cnt  <= next_hold;
            repeating <= next_repeating;
            o_load    <= (next_state == ST_COMMIT);
            o_hours   <= next_hours;
            o_minutes <= next_minutes;
            o_mode    <= next_state;
        end
    end

    // The chain runs only in RUN; decoded straight from the state register so
    // it drops in the same cycle the state leaves RUN.
    assign o_clk_en = (state == ST_RUN);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl
// Self-checking bench for clock_set_ctrl. A behavioural model works from
// elapsed cycle counts (cycles since last event, cycles inc has been held)
// and checks every output after every clock edge. It covers the directed
// scenarios and then a randomized button sequence.
module tb_clock_set_ctrl;

    localparam int TO  = 100;
    localparam int DLY = 20;
    localparam int RPT = 5;

    logic       i_sysclk = 1'b0;
    logic       i_reset_n;
    logic       i_set;
    logic       i_inc;
    logic [4:0] i_hours;
    logic [5:0] i_minutes;
    logic       o_clk_en;
    logic       o_load;
    logic [4:0] o_hours;
    logic [5:0] o_minutes;
    logic [1:0] o_mode;

    int checks = 0;
    int errors = 0;
    int load_seen = 0;

    // Reference model state
    int m_mode, m_hours, m_minutes, m_load;
    int m_prev_set, m_prev_inc, m_hold_run, m_last_evt, m_cyc;

    clock_set_ctrl #(
        .TIMEOUT_CYC   (TO),
        .REPEAT_DLY_CYC(DLY),
        .REPEAT_CYC    (RPT)
    ) dut (
        .i_sysclk (i_sysclk),
        .i_reset_n(i_reset_n),
        .i_set    (i_set),
        .i_inc    (i_inc),
        .i_hours  (i_hours),
        .i_minutes(i_minutes),
        .o_clk_en (o_clk_en),
        .o_load   (o_load),
        .o_hours  (o_hours),
        .o_minutes(o_minutes),
        .o_mode   (o_mode)
    );

    // 100 MHz-style free-running clock
    always #5 i_sysclk = ~i_sysclk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_mode     = 0;
        m_hours    = 0;
        m_minutes  = 0;
        m_load     = 0;
        m_prev_set = 0;
        m_prev_inc = 0;
        m_hold_run = 0;
        m_last_evt = m_cyc;
    endtask

    // One clock edge of the reference behaviour, using the inputs as sampled
    task automatic modelStep();
        int set_p, inc_p, in_set, tick, evt;
        set_p  = (i_set == 1'b1 && m_prev_set == 0) ? 1 : 0;
        inc_p  = (i_inc == 1'b1 && m_prev_inc == 0) ? 1 : 0;
        in_set = (m_mode == 1 || m_mode == 2) ? 1 : 0;
        tick   = 0;
        if (in_set == 1 && i_inc == 1'b1) begin
            if (m_hold_run == DLY) tick = 1;
            if (m_hold_run > DLY && ((m_hold_run - DLY) % RPT) == 0) tick = 1;
        end
        evt = (in_set == 1 && (inc_p == 1 || tick == 1)) ? 1 : 0;

        if (in_set == 1 && i_inc == 1'b1 && set_p == 0) m_hold_run++;
        else m_hold_run = 0;

        m_load = 0;
        case (m_mode)
            0: if (set_p == 1) begin
                m_mode     = 1;
                m_hours    = int'(i_hours);
                m_minutes  = int'(i_minutes);
                m_last_evt = m_cyc;
            end
            1: if (set_p == 1) begin
                m_mode = 2; m_last_evt = m_cyc;
            end else if (evt == 1) begin
                m_hours = (m_hours >= 23) ? 0 : m_hours + 1; m_last_evt = m_cyc;
            end else if (m_cyc - m_last_evt >= TO) begin
                m_mode = 0;
            end
            2: if (set_p == 1) begin
                m_mode = 3; m_load = 1;
            end else if (evt == 1) begin
                m_minutes = (m_minutes >= 59) ? 0 : m_minutes + 1; m_last_evt = m_cyc;
            end else if (m_cyc - m_last_evt >= TO) begin
                m_mode = 0;
            end
            default: m_mode = 0;
        endcase

        m_prev_set = int'(i_set);
        m_prev_inc = int'(i_inc);
        m_cyc++;
    endtask

    task automatic checkAll();
        checkOutput("mode",    int'(o_mode),    m_mode);
        checkOutput("clk_en",  int'(o_clk_en),  (m_mode == 0) ? 1 : 0);
        checkOutput("load",    int'(o_load),    m_load);
        checkOutput("hours",   int'(o_hours),   m_hours);
        checkOutput("minutes", int'(o_minutes), m_minutes);
    endtask

    // Drive buttons, take one edge, advance the model and compare
    task automatic applyStimulus(input logic set, input logic inc);
        i_set = set;
        i_inc = inc;
        @(posedge i_sysclk);
        modelStep();
        #1;
        if (o_load) load_seen++;
        checkAll();
    endtask

    task automatic pressSet();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic pressInc();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic resetUnderTest();
        i_reset_n = 1'b0;
        #1;
        checkOutput("rst_mode",    int'(o_mode),    0);
        checkOutput("rst_load",    int'(o_load),    0);
        checkOutput("rst_clk_en",  int'(o_clk_en),  1);
        checkOutput("rst_hours",   int'(o_hours),   0);
        checkOutput("rst_minutes", int'(o_minutes), 0);
        modelReset();
        @(negedge i_sysclk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        int k;
        int len;
        logic s;
        logic c;

        m_cyc     = 0;
        i_set     = 1'b0;
        i_inc     = 1'b0;
        i_hours   = 5'd0;
        i_minutes = 6'd0;
        i_reset_n = 1'b1;
        #2;

        // Reset release
        $display("[TB] reset release");
        resetUnderTest();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // Reset asserted while in SET_M
        pressSet();
        pressSet();
        checkOutput("in_set_m", int'(o_mode), 2);
        #2;
        load_seen = 0;
        resetUnderTest();
        applyStimulus(1'b0, 1'b0);
        checkOutput("reset_no_load", load_seen, 0);

        // Full edit: 22:58 -> 1:00
        $display("[TB] full edit");
        i_hours   = 5'd22;
        i_minutes = 6'd58;
        load_seen = 0;
        pressSet();
        repeat (3) pressInc();
        checkOutput("edit_hours", int'(o_hours), 1);
        pressSet();
        repeat (2) pressInc();
        checkOutput("edit_minutes", int'(o_minutes), 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("commit_load",  int'(o_load),    1);
        checkOutput("commit_hours", int'(o_hours),   1);
        checkOutput("commit_mode",  int'(o_mode),    3);
        applyStimulus(1'b0, 1'b0);
        checkOutput("commit_run",   int'(o_clk_en),  1);
        checkOutput("load_count",   load_seen,       1);

        // Auto-repeat in SET_M from 0
        $display("[TB] auto-repeat");
        i_hours   = 5'd0;
        i_minutes = 6'd0;
        pressSet();
        pressSet();
        repeat (36) applyStimulus(1'b0, 1'b1);
        checkOutput("repeat_minutes", int'(o_minutes), 5);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("repress_minutes", int'(o_minutes), 6);
        applyStimulus(1'b0, 1'b0);
        pressSet();
        applyStimulus(1'b0, 1'b0);

        // Timeout with no input
        $display("[TB] timeout");
        load_seen = 0;
        pressSet();
        k = 1;
        while (o_mode != 2'b00 && k < 250) begin
            applyStimulus(1'b0, 1'b0);
            k++;
        end
        checkOutput("timeout_cycles", k, TO);
        checkOutput("timeout_clk_en", int'(o_clk_en), 1);

        // Timeout extended by an inc at cycle 90
        pressSet();
        k = 1;
        repeat (88) begin
            applyStimulus(1'b0, 1'b0);
            k++;
        end
        applyStimulus(1'b0, 1'b1);
        k++;
        while (o_mode != 2'b00 && k < 350) begin
            applyStimulus(1'b0, 1'b0);
            k++;
        end
        checkOutput("timeout_ext_cycles", k, 190);
        checkOutput("timeout_no_load", load_seen, 0);

        // Simultaneous set and inc press in SET_H
        $display("[TB] simultaneous press");
        i_hours   = 5'd5;
        i_minutes = 6'd10;
        pressSet();
        applyStimulus(1'b1, 1'b1);
        checkOutput("simul_mode",  int'(o_mode),  2);
        checkOutput("simul_hours", int'(o_hours), 5);
        applyStimulus(1'b0, 1'b0);
        pressSet();
        applyStimulus(1'b0, 1'b0);

        // Out-of-range capture, then inc in RUN
        $display("[TB] out-of-range capture");
        i_hours = 5'd30;
        pressSet();
        checkOutput("oor_capture", int'(o_hours), 30);
        pressInc();
        checkOutput("oor_wrap", int'(o_hours), 0);
        pressSet();
        pressSet();
        applyStimulus(1'b0, 1'b0);
        load_seen = 0;
        repeat (3) pressInc();
        checkOutput("run_inc_hours", int'(o_hours), 0);
        checkOutput("run_inc_load",  load_seen,     0);

        // Randomized button sequences
        $display("[TB] random phase");
        for (int seg = 0; seg < 150; seg++) begin
            len = $urandom_range(1, 30);
            s   = ($urandom_range(0, 3) == 0);
            c   = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0) begin
                s   = 1'b0;
                c   = 1'b0;
                len = 110;
            end
            i_hours   = 5'($urandom_range(0, 31));
            i_minutes = 6'($urandom_range(0, 63));
            for (int j = 0; j < len; j++) applyStimulus(s, c);
            if ($urandom_range(0, 1) == 1) applyStimulus(1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-set controller for the basic clock counter chain. Sequences the user's set and increment buttons through a small state machine. While the user is editing hours and minutes, it freezes the counter chain's enable. When editing completes, it issues a single load pulse carrying the edited values. It sits between the debounced button inputs and the `i_en`/load inputs of the seconds/minutes/hours counters, and also drives the display-mode field.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 500_000_000: idle cycles in a set state before it abandons editing (10 s at 50 MHz).
- `REPEAT_DLY_CYC`, default 25_000_000: cycles `i_inc` must be held before auto-repeat starts.
- `REPEAT_CYC`, default 5_000_000: cycles between auto-repeat increments.

Ports:
- `i_sysclk`  in  1: system clock (~50 MHz); the block's only clock.
- `i_reset_n`  in  1: reset, asynchronous, active-low.
- `i_set`  in  1: set button, debounced level, synchronous to `i_sysclk`.
- `i_inc`  in  1: increment button, debounced level, synchronous to `i_sysclk`.
- `i_hours`  in  5: live hours from the counter chain.
- `i_minutes`  in  6: live minutes from the counter chain.
- `o_clk_en`  out  1: enable to the counter chain; 1 only in RUN.
- `o_load`  out  1: one-cycle pulse; the consumer loads `o_hours`/`o_minutes` and clears seconds to 0.
- `o_hours`  out  5: shadow hours.
- `o_minutes`  out  6: shadow minutes.
- `o_mode`  out  2: 00 RUN, 01 SET_H, 10 SET_M, 11 COMMIT.

## Operation
Press detection:
- One register each holds the previous `i_set` and `i_inc`.
- A press is `level & ~prev`.
- `inc_evt` is an `i_inc` press or an auto-repeat tick. Both count only in SET_H and SET_M.
- If a set press and an `inc_evt` occur in the same cycle, set wins and the increment is dropped.

States:
- **RUN:**
  - `o_clk_en` = 1.
  - A set press captures `i_hours`/`i_minutes` into the shadows and moves to SET_H.
  - `i_inc` is ignored.
- **SET_H:**
  - `inc_evt` does hours ← (hours ≥ 23) ? 0 : hours+1.
  - A set press moves to SET_M.
- **SET_M:**
  - `inc_evt` does minutes ← (minutes ≥ 59) ? 0 : minutes+1.
  - There is no carry into hours.
  - A set press moves to COMMIT.
- **COMMIT:**
  - `o_load` = 1 for exactly this cycle, then unconditionally RUN.
  - Button presses are ignored.
- **Timeout:**
  - In SET_H/SET_M, the idle counter clears on any set press or `inc_evt` and otherwise increments.
  - At `TIMEOUT_CYC` the block goes to RUN with no load pulse. The counter chain resumes from its frozen value.
  - Shadows keep their edited values until the next capture.
- **Auto-repeat:**
  - The hold counter clears when `i_inc` = 0 or the state is not SET_H/SET_M.
  - While held, it counts. A tick fires when the count reaches `REPEAT_DLY_CYC`, then every `REPEAT_CYC` after that.
  - On a state change to SET_M while `i_inc` is held, the hold counter restarts from 0 at that edge.
- Counter widths are `$clog2` of the respective parameter + 1, and counters saturate rather than wrap.
- The ≥ comparisons make out-of-range captured values (e.g. hours = 30) wrap to 0 on the first increment.

## Timing
- Reset values, applied immediately on `i_reset_n` low:
  - state RUN, so `o_clk_en` = 1 after reset releases;
  - `o_load` 0, `o_hours` 0, `o_minutes` 0, `o_mode` 00;
  - all counters and edge registers 0.
- Reset asserted mid-edit returns to RUN with no `o_load`.
- A press first sampled at edge N (level 1, prev 0) takes effect at edge N:
  - the state, shadow update and `o_clk_en` change are all visible after N;
  - `o_clk_en` falls in the same cycle the state leaves RUN, so at most zero extra counts reach the chain.
- Commit: a set press in SET_M at edge N gives `o_load` = 1 from N to N+1 and RUN after N+1, so `o_clk_en` = 1 from N+1.
- Repeat: with the press at edge N, increments occur at N, N+`REPEAT_DLY_CYC`, N+`REPEAT_DLY_CYC`+k·`REPEAT_CYC`.
- Timeout: with the last event at edge N, the transition to RUN happens at edge N+`TIMEOUT_CYC`.
- `o_mode`, `o_hours`, `o_minutes` and `o_load` are registered outputs. `o_clk_en` is decoded from the state register.

## Test plan
All scenarios use `TIMEOUT_CYC`=100, `REPEAT_DLY_CYC`=20, `REPEAT_CYC`=5.
- **Reset release:** `o_clk_en`=1, `o_mode`=00, `o_load`=0, shadows 0. Then assert reset while in SET_M: immediately `o_mode`=00, no load.
- **Full edit:**
  - With `i_hours`=22, `i_minutes`=58: press set; inc ×3; set; inc ×2; set.
  - Expect hours 22→23→0→1 and minutes 58→59→0.
  - Expect exactly one `o_load` cycle with 1:00, `o_mode` sequence 01,10,11,00, and `o_clk_en` low throughout.
- **Auto-repeat:**
  - In SET_M from 0, hold `i_inc` for 36 cycles from press edge N.
  - Expect increments at N, N+20, N+25, N+30, N+35, so minutes = 5.
  - Release and re-press: +1 immediately.
- **Timeout:**
  - Enter SET_H, apply no input.
  - Expect the return to 00 exactly 100 cycles after entry, with `o_load` never asserted and `o_clk_en` back to 1.
  - Also: an inc at cycle 90 extends the timeout to cycle 190.
- **Simultaneous press:** In SET_H with hours=5, set and inc rise on the same edge → state SET_M, hours stays 5.
- **Out-of-range capture and RUN-state inc:**
  - Capture `i_hours`=30, then inc → 0.
  - In RUN, `i_inc` pulses produce no shadow change and no load.
